multicycle_control: RTL and testbench

- Control unit for the multi-cycle RV32I core.
- Sits directly upstream of the datapath: consumes the datapath's opcode, funct3, funct7[5] and ALU zero flag, and drives every datapath control select and enable.
- Main-decoder Moore FSM, plus combinational ALU decoder and immediate-source decoder.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.

---
 rtl/multicycle_pkg.sv | 68 ++++++
 rtl/alu_decoder.sv | 30 +++
 rtl/multicycle_control.sv | 153 +++++++++++++++
 tb/tb_multicycle_control.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared types, opcodes and select encodings for the multi-cycle control unit
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_A     = 2'b10;

   localparam logic [1:0] SRCB_WD   = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic op_is_legal(input logic [6:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_ITYPE) || (op == OP_BEQ) || (op == OP_JAL);
   endfunction

   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_BEQ:  return IMM_B;
         OP_JAL:  return IMM_J;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALUOp and funct fields onto the ALU operation code
module alu_decoder
   import multicycle_pkg::*;
(
   input  logic [1:0] i_ALUOp,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7_5,
   input  logic       i_op_5,
   output logic [2:0] o_ALUControl
);

   always_comb begin
      o_ALUControl = ALU_ADD;
      case (i_ALUOp)
         ALUOP_SUB:   o_ALUControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct3)
               // op[5] separates R-type sub from addi, whose imm[10] lands on funct7_5
               3'b000:  o_ALUControl = (i_op_5 & i_funct7_5) ? ALU_SUB : ALU_ADD;
               3'b010:  o_ALUControl = ALU_SLT;
               3'b110:  o_ALUControl = ALU_OR;
               3'b111:  o_ALUControl = ALU_AND;
               default: o_ALUControl = ALU_ADD;
            endcase
         end
         default:     o_ALUControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32I control unit: Moore main decoder plus ALU/immediate decode
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter state_t RESET_STATE = S_FETCH
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic [6:0] i_OpCode,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7_5,
   input  logic       i_Zero,
   output logic       o_PCWrite,
   output logic       o_AdrSrc,
   output logic       o_IRWrite,
   output logic [1:0] o_ResultSrc,
   output logic       o_MemWrite,
   output logic [1:0] o_ALUSrcA,
   output logic [1:0] o_ALUSrcB,
   output logic [1:0] o_ImmSrc,
   output logic       o_RegWrite,
   output logic [2:0] o_ALUControl,
   output logic       o_InstrDone,
   output logic       o_Illegal
);

   state_t r_state;
   state_t w_next_state;
   logic   r_illegal;
   aluop_t w_aluop;
   logic   w_pc_update;
   logic   w_branch;
   logic   w_op_legal;

   assign w_op_legal = op_is_legal(i_OpCode);

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_state   <= RESET_STATE;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_DECODE && !w_op_legal)
            r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_next_state = S_FETCH;
      case (r_state)
         S_FETCH:  w_next_state = S_DECODE;
         S_DECODE: begin
            case (i_OpCode)
               OP_LW, OP_SW: w_next_state = S_MEMADR;
               OP_RTYPE:     w_next_state = S_EXECR;
               OP_ITYPE:     w_next_state = S_EXECI;
               OP_BEQ:       w_next_state = S_BEQ;
               OP_JAL:       w_next_state = S_JAL;
               default:      w_next_state = S_FETCH;
            endcase
         end
         S_MEMADR:  w_next_state = i_OpCode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: w_next_state = S_MEMWB;
         S_EXECR:   w_next_state = S_ALUWB;
         S_EXECI:   w_next_state = S_ALUWB;
         S_JAL:     w_next_state = S_ALUWB;
         default:   w_next_state = S_FETCH;
      endcase
   end

   // Reset masks every state-decoded output so a half-finished instruction cannot write anything
   always_comb begin
      w_pc_update = 1'b0;
      w_branch    = 1'b0;
      w_aluop     = ALUOP_ADD;
      o_AdrSrc    = 1'b0;
      o_IRWrite   = 1'b0;
      o_ResultSrc = RES_ALUOUT;
      o_MemWrite  = 1'b0;
      o_ALUSrcA   = SRCA_PC;
      o_ALUSrcB   = SRCB_WD;
      o_RegWrite  = 1'b0;
      o_InstrDone = 1'b0;
      if (!i_Reset) begin
         case (r_state)
            S_FETCH: begin
               o_IRWrite   = 1'b1;
               o_ALUSrcB   = SRCB_FOUR;
               o_ResultSrc = RES_ALURESULT;
               w_pc_update = 1'b1;
            end
            S_DECODE: begin
               o_ALUSrcA   = SRCA_OLDPC;
               o_ALUSrcB   = SRCB_IMM;
               o_InstrDone = !w_op_legal;
            end
            S_MEMADR: begin
               o_ALUSrcA = SRCA_A;
               o_ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: o_AdrSrc = 1'b1;
            S_MEMWB: begin
               o_ResultSrc = RES_DATA;
               o_RegWrite  = 1'b1;
               o_InstrDone = 1'b1;
            end
            S_MEMWRITE: begin
               o_AdrSrc    = 1'b1;
               o_MemWrite  = 1'b1;
               o_InstrDone = 1'b1;
            end
            S_EXECR: begin
               o_ALUSrcA = SRCA_A;
               w_aluop   = ALUOP_FUNCT;
            end
            S_EXECI: begin
               o_ALUSrcA = SRCA_A;
               o_ALUSrcB = SRCB_IMM;
               w_aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
               o_RegWrite  = 1'b1;
               o_InstrDone = 1'b1;
            end
            S_BEQ: begin
               o_ALUSrcA   = SRCA_A;
               w_aluop     = ALUOP_SUB;
               w_branch    = 1'b1;
               o_InstrDone = 1'b1;
            end
            S_JAL: begin
               o_ALUSrcA   = SRCA_OLDPC;
               o_ALUSrcB   = SRCB_FOUR;
               w_pc_update = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_PCWrite = w_pc_update | (w_branch & i_Zero);
   assign o_ImmSrc  = imm_src_of(i_OpCode);
   assign o_Illegal = r_illegal;

   alu_decoder u_alu_decoder (
      .i_ALUOp      (w_aluop),
      .i_funct3     (i_funct3),
      .i_funct7_5   (i_funct7_5),
      .i_op_5       (i_OpCode[5]),
      .o_ALUControl (o_ALUControl)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control with a per-instruction reference model
module tb_multicycle_control;

   localparam logic [6:0] LW = 7'b0000011;
   localparam logic [6:0] SW = 7'b0100011;
   localparam logic [6:0] RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011;
   localparam logic [6:0] BQ = 7'b1100011;
   localparam logic [6:0] JL = 7'b1101111;

   localparam int P_FETCH  = 0;
   localparam int P_DECODE = 1;
   localparam int P_ADDR   = 2;
   localparam int P_READ   = 3;
   localparam int P_LOADWB = 4;
   localparam int P_WRITE  = 5;
   localparam int P_EXEC   = 6;
   localparam int P_ALUWB  = 7;
   localparam int P_BRANCH = 8;
   localparam int P_JUMP   = 9;
   localparam int P_RESET  = 10;

   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       irw;
      logic [1:0] res;
      logic       memw;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] imm;
      logic       regw;
      logic [2:0] alu;
      logic       done;
      logic       ill;
   } exp_t;

   logic       i_Clk = 1'b0;
   logic       i_Reset = 1'b1;
   logic [6:0] i_OpCode = 7'd0;
   logic [2:0] i_funct3 = 3'd0;
   logic       i_funct7_5 = 1'b0;
   logic       i_Zero = 1'b0;
   logic       o_PCWrite, o_AdrSrc, o_IRWrite, o_MemWrite, o_RegWrite, o_InstrDone, o_Illegal;
   logic [1:0] o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ImmSrc;
   logic [2:0] o_ALUControl;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   logic sticky = 1'b0;

   multicycle_control dut (
      .i_Clk        (i_Clk),
      .i_Reset      (i_Reset),
      .i_OpCode     (i_OpCode),
      .i_funct3     (i_funct3),
      .i_funct7_5   (i_funct7_5),
      .i_Zero       (i_Zero),
      .o_PCWrite    (o_PCWrite),
      .o_AdrSrc     (o_AdrSrc),
      .o_IRWrite    (o_IRWrite),
      .o_ResultSrc  (o_ResultSrc),
      .o_MemWrite   (o_MemWrite),
      .o_ALUSrcA    (o_ALUSrcA),
      .o_ALUSrcB    (o_ALUSrcB),
      .o_ImmSrc     (o_ImmSrc),
      .o_RegWrite   (o_RegWrite),
      .o_ALUControl (o_ALUControl),
      .o_InstrDone  (o_InstrDone),
      .o_Illegal    (o_Illegal)
   );

   always #5 i_Clk = ~i_Clk;

   function automatic bit is_legal(input logic [6:0] op);
      return op == LW || op == SW || op == RT || op == IT || op == BQ || op == JL;
   endfunction

   // Cycle counts per instruction class: lw 5, sw/R/I/jal 4, beq 3, illegal 2
   function automatic int n_cycles(input logic [6:0] op);
      case (op)
         LW:             return 5;
         SW, RT, IT, JL: return 4;
         BQ:             return 3;
         default:        return 2;
      endcase
   endfunction

   function automatic int step_at(input logic [6:0] op, input int k);
      if (k == 0) return P_FETCH;
      if (k == 1) return P_DECODE;
      case (op)
         LW:      return (k == 2) ? P_ADDR : ((k == 3) ? P_READ : P_LOADWB);
         SW:      return (k == 2) ? P_ADDR : P_WRITE;
         RT, IT:  return (k == 2) ? P_EXEC : P_ALUWB;
         JL:      return (k == 2) ? P_JUMP : P_ALUWB;
         default: return P_BRANCH;
      endcase
   endfunction

   function automatic logic [2:0] funct_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      if (f3 == 3'd0) return (op[5] && f7) ? 3'd1 : 3'd0;
      if (f3 == 3'd2) return 3'd5;
      if (f3 == 3'd6) return 3'd3;
      if (f3 == 3'd7) return 3'd2;
      return 3'd0;
   endfunction

   function automatic exp_t exp_of(input int step, input logic [6:0] op, input logic [2:0] f3,
                                   input logic f7, input logic zero, input logic ill);
      exp_t e;
      e = '0;
      e.ill = ill;
      e.imm = (op == SW) ? 2'd1 : (op == BQ) ? 2'd2 : (op == JL) ? 2'd3 : 2'd0;
      case (step)
         P_FETCH:  begin e.pcw = 1; e.irw = 1; e.res = 2'd2; e.sb = 2'd2; end
         P_DECODE: begin e.sa = 2'd1; e.sb = 2'd1; e.done = !is_legal(op); end
         P_ADDR:   begin e.sa = 2'd2; e.sb = 2'd1; end
         P_READ:   e.adr = 1;
         P_LOADWB: begin e.res = 2'd1; e.regw = 1; e.done = 1; end
         P_WRITE:  begin e.adr = 1; e.memw = 1; e.done = 1; end
         P_EXEC:   begin e.sa = 2'd2; e.sb = (op == RT) ? 2'd0 : 2'd1; e.alu = funct_alu(op, f3, f7); end
         P_ALUWB:  begin e.regw = 1; e.done = 1; end
         P_BRANCH: begin e.sa = 2'd2; e.alu = 3'd1; e.pcw = zero; e.done = 1; end
         P_JUMP:   begin e.sa = 2'd1; e.sb = 2'd2; e.pcw = 1; end
         default:  ;
      endcase
      return e;
   endfunction

   // zmode: 0/1 forces i_Zero, 2 randomises it every cycle; abort_at asserts reset in that cycle
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input int zmode, input int abort_at);
      int  n;
      int  step;
      bit  stop;
      n = n_cycles(op);
      stop = 0;
      for (int k = 0; k < n && !stop; k++) begin
         @(posedge i_Clk);
         #1;
         i_OpCode   = (k == 0) ? 7'($urandom) : op;
         i_funct3   = f3;
         i_funct7_5 = f7;
         i_Zero     = (zmode == 2) ? 1'($urandom) : (zmode == 1);
         i_Reset    = (k == abort_at);
         step = i_Reset ? P_RESET : step_at(op, k);
         exp_q.push_back(exp_of(step, i_OpCode, f3, f7, i_Zero, sticky));
         if (i_Reset) begin
            sticky = 0;
            stop = 1;
         end else if (step == P_DECODE && !is_legal(op)) begin
            sticky = 1;
         end
      end
   endtask

   always @(negedge i_Clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         exp_t a;
         e = exp_q.pop_front();
         a = {o_PCWrite, o_AdrSrc, o_IRWrite, o_ResultSrc, o_MemWrite, o_ALUSrcA, o_ALUSrcB,
              o_ImmSrc, o_RegWrite, o_ALUControl, o_InstrDone, o_Illegal};
         n_checks++;
         if (a === e)
            n_pass++;
         else
            $display("FAIL cycle_outputs t=%0t actual=%05h required=%05h (pcw adr irw res memw sa sb imm regw alu done ill)",
                     $time, a, e);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         pick;
      int         ab;
      logic [6:0] op;
      @(posedge i_Clk);
      #1;
      i_OpCode = 7'($urandom);
      exp_q.push_back(exp_of(P_RESET, i_OpCode, 3'd0, 1'b0, 1'b0, 1'b0));

      run_instr(LW, 3'd0, 1'b0, 2, -1);
      run_instr(SW, 3'd0, 1'b0, 2, -1);
      run_instr(RT, 3'd0, 1'b1, 2, -1);
      run_instr(IT, 3'd0, 1'b1, 2, -1);
      run_instr(RT, 3'd2, 1'b0, 2, -1);
      run_instr(BQ, 3'd0, 1'b0, 1, -1);
      run_instr(BQ, 3'd0, 1'b0, 0, -1);
      run_instr(JL, 3'd0, 1'b0, 2, -1);
      run_instr(7'h7f, 3'd0, 1'b0, 2, -1);
      run_instr(LW, 3'd7, 1'b0, 2, -1);
      run_instr(SW, 3'd0, 1'b0, 2, 3);
      run_instr(RT, 3'd6, 1'b0, 2, -1);

      for (int i = 0; i < 80; i++) begin
         pick = int'($urandom_range(0, 7));
         case (pick)
            0:       op = LW;
            1:       op = SW;
            2:       op = RT;
            3:       op = IT;
            4:       op = BQ;
            5:       op = JL;
            6:       op = 7'($urandom);
            default: op = 7'h7f;
         endcase
         ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n_cycles(op) - 1)) : -1;
         run_instr(op, 3'($urandom), 1'($urandom), 2, ab);
      end

      repeat (2) @(posedge i_Clk);
      #2;
      n_checks++;
      if (exp_q.size() == 0)
         n_pass++;
      else
         $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
